// File: rtl/cla_pipe.sv
// Pipelined carry-lookahead adder/subtractor.
//
// The WIDTH-bit operation is cut into STAGES slices of WIDTH/STAGES bits.
// Pipeline rank k adds slice k with a 4-bit-group CLA plus a lookahead unit
// across the groups, registers the slice carry-out and carries the whole
// operand pair forward so later ranks can pick up their own slice.
// Subtraction is a + ~b + ~cIn, so cOut = 1 means "no borrow".
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   inValid / inReady   operand handshake (inReady = advance, combinational)
//   a, b, cIn, sub      operands, carry/borrow in, 0 = add / 1 = subtract
//   outValid / outReady result handshake
//   s, cOut, ovf, zero  result, carry out, signed overflow, s == 0

module cla_pipe_slice #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co,
    output logic         c_msb
);
    localparam int NG = W / 4;

    logic [W-1:0]  g, p;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic [W:0]    c;
    logic          acc, pp;

    assign g = x & y;
    assign p = x ^ y;

    // Group generate / propagate for each 4-bit group.
    always_comb begin
        gg = '0;
        gp = '0;
        for (int j = 0; j < NG; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
    end

    // Lookahead unit: every group carry is an independent sum of products
    // of the group G/P terms and ci, not a chain through the previous group.
    always_comb begin
        gc    = '0;
        gc[0] = ci;
        acc   = 1'b0;
        pp    = 1'b1;
        for (int j = 1; j <= NG; j++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int i = j - 1; i >= 0; i--) begin
                acc = acc | (gg[i] & pp);
                pp  = pp & gp[i];
            end
            gc[j] = acc | (pp & ci);
        end
    end

    // Bit carries inside each group, again in flattened lookahead form.
    always_comb begin
        c = '0;
        for (int j = 0; j < NG; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
        end
        c[W] = gc[NG];
    end

    assign sum   = p ^ c[W-1:0];
    assign co    = c[W];
    assign c_msb = c[W-1];
endmodule

module cla_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cIn,
    input  logic             sub,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] s,
    output logic             cOut,
    output logic             ovf,
    output logic             zero
);
    localparam int SW = WIDTH / STAGES;

    logic                           advance;
    logic [STAGES-1:0]              vld_q, in_v;
    logic [STAGES-1:0][WIDTH-1:0]   a_q, b_q, sum_q;
    logic [STAGES-1:0][WIDTH-1:0]   in_a, in_b, in_sum, sum_d;
    logic [STAGES-1:0]              c_q, in_c, c_d;
    logic                           ovf_q, ovf_d;
    logic                           zero_q, zero_d;
    logic                           unused_ops;

    // Whole pipeline moves together; a held result freezes every rank.
    assign advance = !vld_q[STAGES-1] || outReady;
    assign inReady = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam logic [WIDTH-1:0] MASK = WIDTH'({SW{1'b1}}) << (k * SW);

        logic [SW-1:0] sl_s;
        logic          sl_co, sl_cmsb;

        if (k == 0) begin : g_in0
            // Subtract folds into the first rank: invert b and the carry.
            assign in_a[k]   = a;
            assign in_b[k]   = b ^ {WIDTH{sub}};
            assign in_c[k]   = cIn ^ sub;
            assign in_sum[k] = '0;
            assign in_v[k]   = inValid;
        end else begin : g_inn
            assign in_a[k]   = a_q[k-1];
            assign in_b[k]   = b_q[k-1];
            assign in_c[k]   = c_q[k-1];
            assign in_sum[k] = sum_q[k-1];
            assign in_v[k]   = vld_q[k-1];
        end

        cla_pipe_slice #(.W(SW)) u_slice (
            .x     (in_a[k][k*SW +: SW]),
            .y     (in_b[k][k*SW +: SW]),
            .ci    (in_c[k]),
            .sum   (sl_s),
            .co    (sl_co),
            .c_msb (sl_cmsb)
        );

        // Keep the already-computed low slices, drop in this rank's slice.
        assign sum_d[k] = (in_sum[k] & ~MASK) | (WIDTH'(sl_s) << (k * SW));
        assign c_d[k]   = sl_co;

        if (k == STAGES - 1) begin : g_ovf
            assign ovf_d = sl_cmsb ^ sl_co;
        end else begin : g_nov
            logic unused_cmsb;
            assign unused_cmsb = sl_cmsb;
        end
    end

    assign zero_d = (sum_d[STAGES-1] == '0);

    // Operand bits below a rank's slice are dead once that rank is passed.
    assign unused_ops = ^{a_q, b_q};

    // Data registers load only with a valid op, so a drained pipeline keeps
    // showing the last result (or zeros after reset) rather than bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            vld_q <= in_v;
            for (int k = 0; k < STAGES; k++) begin
                if (in_v[k]) begin
                    a_q[k]   <= in_a[k];
                    b_q[k]   <= in_b[k];
                    sum_q[k] <= sum_d[k];
                    c_q[k]   <= c_d[k];
                end
            end
            if (in_v[STAGES-1]) begin
                ovf_q  <= ovf_d;
                zero_q <= zero_d;
            end
        end
    end

    assign outValid = vld_q[STAGES-1];
    assign s        = sum_q[STAGES-1];
    assign cOut     = c_q[STAGES-1];
    assign ovf      = ovf_q;
    assign zero     = zero_q;
endmodule

// File: tb/tb_cla_pipe.sv
// Bench for cla_pipe: directed vector table, multi-cycle handshake/reset
// sequences and a randomized scoreboard on a 32/2 instance, plus a sweep of
// nine WIDTH x STAGES instances against an arithmetic reference.
module tb_cla_pipe;
    typedef struct {
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sb;
        logic [31:0] es;
        logic        eco;
        logic        eov;
        logic        ez;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;
    int sw_done = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, sw_rst;
    logic        inValid, inReady, outValid, outReady;
    logic [31:0] a, b, s;
    logic        cIn, sub, cOut, ovf, zero;

    cla_pipe #(.WIDTH(32), .STAGES(2)) dut (
        .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
        .a(a), .b(b), .cIn(cIn), .sub(sub), .outValid(outValid),
        .outReady(outReady), .s(s), .cOut(cOut), .ovf(ovf), .zero(zero)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    // Reference: plain integer arithmetic on w-bit values.
    function automatic res_t ref_op(input int w, input logic [63:0] av, input logic [63:0] bv,
                                    input logic cin, input logic sb);
        res_t res;
        logic [65:0] one, mask, ua, ub, r;
        logic signed [67:0] sa, sbv, ci, sr, hi, lo;
        one  = 66'd1;
        mask = (one << w) - 66'd1;
        ua   = {2'b00, av} & mask;
        ub   = {2'b00, bv} & mask;
        if (!sb) r = ua + ub + {65'd0, cin};
        else     r = ua - ub - {65'd0, cin};
        res.s  = r[63:0] & mask[63:0];
        res.co = sb ? (ua >= ub + {65'd0, cin}) : r[w];
        sa  = $signed({2'b00, ua});
        if (ua[w-1]) sa = sa - $signed({2'b00, one << w});
        sbv = $signed({2'b00, ub});
        if (ub[w-1]) sbv = sbv - $signed({2'b00, one << w});
        ci  = $signed({67'd0, cin});
        sr  = sb ? (sa - sbv - ci) : (sa + sbv + ci);
        hi  = $signed({2'b00, one << (w - 1)}) - 68'sd1;
        lo  = -$signed({2'b00, one << (w - 1)});
        res.ov = (sr > hi) || (sr < lo);
        res.z  = (res.s == 64'd0);
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb);
        inValid = 1'b1; a = av; b = bv; cIn = ci; sub = sb;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    // Scoreboard for the main instance: accepted ops queue their expected
    // result; every presented result must match in order; stalled outputs
    // must not change.
    res_t        mq[$];
    res_t        mr;
    logic        stall_v = 1'b0;
    logic [34:0] held;
    always @(negedge clk) begin
        if (reset) begin
            mq.delete();
            stall_v = 1'b0;
        end else begin
            if (stall_v && outValid) chk("hold_stable", {29'd0, s, cOut, ovf, zero}, {29'd0, held});
            if (outValid && outReady) begin
                chk("sb_pending", mq.size() != 0, 1);
                if (mq.size() != 0) begin
                    mr = mq.pop_front();
                    chk("sb_s", 64'(s), mr.s);
                    chk("sb_cout", cOut, mr.co);
                    chk("sb_ovf", ovf, mr.ov);
                    chk("sb_zero", zero, mr.z);
                end
            end
            stall_v = outValid && !outReady;
            held    = {s, cOut, ovf, zero};
            if (inValid && inReady) mq.push_back(ref_op(32, 64'(a), 64'(b), cIn, sub));
        end
    end

    // Parameter sweep: nine instances, free-flowing output, random input.
    for (genvar gi = 0; gi < 9; gi++) begin : g_sw
        localparam int W = (gi / 3 == 0) ? 16 : ((gi / 3 == 1) ? 32 : 64);
        localparam int S = (gi % 3 == 0) ? 1 : ((gi % 3 == 1) ? 2 : 4);
        logic         sv_iv, sv_ir, sv_ov, sv_or, sv_cin, sv_sub, sv_co, sv_ovf, sv_z;
        logic [W-1:0] sv_a, sv_b, sv_s;
        res_t         q[$];
        res_t         r;

        cla_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk(clk), .reset(sw_rst), .inValid(sv_iv), .inReady(sv_ir),
            .a(sv_a), .b(sv_b), .cIn(sv_cin), .sub(sv_sub), .outValid(sv_ov),
            .outReady(sv_or), .s(sv_s), .cOut(sv_co), .ovf(sv_ovf), .zero(sv_z)
        );

        initial begin
            sv_iv = 1'b0; sv_or = 1'b1; sv_a = '0; sv_b = '0; sv_cin = 1'b0; sv_sub = 1'b0;
            @(posedge clk);
            while (sw_rst) @(posedge clk);
            for (int i = 0; i < 60; i++) begin
                @(posedge clk);
                #1;
                sv_iv  = $urandom_range(0, 3) != 0;
                sv_a   = W'({$urandom, $urandom});
                sv_b   = W'({$urandom, $urandom});
                sv_cin = 1'($urandom);
                sv_sub = 1'($urandom);
            end
            @(posedge clk);
            #1;
            sv_iv = 1'b0;
            repeat (S + 2) @(posedge clk);
            #1;
            chk("sweep_drain", 64'(q.size()), 0);
            sw_done++;
        end

        always @(negedge clk) begin
            if (!sw_rst) begin
                if (sv_ov) begin
                    chk("sweep_pending", q.size() != 0, 1);
                    if (q.size() != 0) begin
                        r = q.pop_front();
                        chk("sweep_s", 64'(sv_s), r.s);
                        chk("sweep_cout", sv_co, r.co);
                        chk("sweep_ovf", sv_ovf, r.ov);
                        chk("sweep_zero", sv_z, r.z);
                    end
                end
                if (sv_iv && sv_ir) q.push_back(ref_op(W, 64'(sv_a), 64'(sv_b), sv_cin, sv_sub));
            end
        end
    end

    vec_t vt[11];
    int   k;

    initial begin
        vt[0]  = '{32'hFFFFFFFF, 32'h00000001, 0, 0, 32'h00000000, 1, 0, 1};
        vt[1]  = '{32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1, 0};
        vt[2]  = '{32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1, 0};
        vt[3]  = '{32'h00000005, 32'h00000005, 0, 1, 32'h00000000, 1, 0, 1};
        vt[4]  = '{32'h00000000, 32'h00000001, 0, 1, 32'hFFFFFFFF, 0, 0, 0};
        vt[5]  = '{32'h00000001, 32'h00000001, 1, 0, 32'h00000003, 0, 0, 0};
        vt[6]  = '{32'h0000000A, 32'h00000003, 1, 1, 32'h00000006, 1, 0, 0};
        vt[7]  = '{32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1, 1};
        vt[8]  = '{32'h0000FFFF, 32'h00000001, 0, 0, 32'h00010000, 0, 0, 0};
        vt[9]  = '{32'h00000000, 32'h00000000, 1, 1, 32'hFFFFFFFF, 0, 0, 0};
        vt[10] = '{32'h12345678, 32'h0FEDCBA8, 0, 0, 32'h22222220, 0, 0, 0};

        reset = 1'b1; sw_rst = 1'b1; inValid = 1'b0; outReady = 1'b1;
        a = '0; b = '0; cIn = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; sw_rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_outValid", outValid, 0);
        chk("rst_inReady", inReady, 1);
        chk("rst_s", 64'(s), 0);
        chk("rst_cout", cOut, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_zero", zero, 0);

        // Directed vectors, one at a time, with exact two-cycle latency
        for (int i = 0; i < 11; i++) begin
            tick();
            drive(vt[i].a, vt[i].b, vt[i].cin, vt[i].sb);
            tick();
            inValid = 1'b0;
            @(negedge clk);
            chk("vec_lat1_valid", outValid, 0);
            tick();
            @(negedge clk);
            chk("vec_valid", outValid, 1);
            chk("vec_s", 64'(s), 64'(vt[i].es));
            chk("vec_cout", cOut, vt[i].eco);
            chk("vec_ovf", ovf, vt[i].eov);
            chk("vec_zero", zero, vt[i].ez);
        end

        // Back-to-back stream: results on consecutive cycles from cycle 2
        k = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (c < 8) drive(32'(c), 32'(3 * c), 1'b0, 1'b0);
            else inValid = 1'b0;
            @(negedge clk);
            if (outValid) begin
                chk("stream_cycle", 64'(c), 64'(k + 2));
                chk("stream_s", 64'(s), 64'(4 * k));
                k++;
            end
        end
        chk("stream_count", 64'(k), 8);

        // Backpressure with a full pipeline
        tick();
        outReady = 1'b0;
        drive(32'd100, 32'd1, 1'b0, 1'b0);
        tick();
        drive(32'd200, 32'd2, 1'b0, 1'b0);
        tick();
        drive(32'd300, 32'd3, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_inReady", inReady, 0);
            chk("bp_outValid", outValid, 1);
            chk("bp_s", 64'(s), 101);
            tick();
        end
        outReady = 1'b1;
        @(negedge clk);
        chk("bp_rel_inReady", inReady, 1);
        chk("bp_rel_s0", 64'(s), 101);
        tick();
        inValid = 1'b0;
        @(negedge clk);
        chk("bp_rel_v1", outValid, 1);
        chk("bp_rel_s1", 64'(s), 202);
        tick();
        @(negedge clk);
        chk("bp_rel_v2", outValid, 1);
        chk("bp_rel_s2", 64'(s), 303);
        tick();
        @(negedge clk);
        chk("bp_drained", outValid, 0);

        // Reset mid-flight, with an operand offered during reset
        tick();
        drive(32'd1, 32'd2, 1'b0, 1'b0);
        tick();
        drive(32'd3, 32'd4, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        drive(32'd5, 32'd6, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        inValid = 1'b0;
        @(negedge clk);
        chk("midrst_s", 64'(s), 0);
        chk("midrst_inReady", inReady, 1);
        for (int i = 0; i < 4; i++) begin
            chk("midrst_outValid", outValid, 0);
            tick();
            @(negedge clk);
        end
        tick();
        drive(32'd9, 32'd9, 1'b0, 1'b1);
        tick();
        inValid = 1'b0;
        @(negedge clk);
        chk("midrst_lat1", outValid, 0);
        tick();
        @(negedge clk);
        chk("midrst_valid", outValid, 1);
        chk("midrst_res_s", 64'(s), 0);
        chk("midrst_res_zero", zero, 1);
        chk("midrst_res_cout", cOut, 1);

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            tick();
            outReady = $urandom_range(0, 3) != 0;
            inValid  = $urandom_range(0, 9) < 7;
            a   = pick();
            b   = pick();
            cIn = 1'($urandom);
            sub = 1'($urandom);
        end
        tick();
        inValid  = 1'b0;
        outReady = 1'b1;
        repeat (5) tick();
        chk("rand_drain", 64'(mq.size()), 0);

        for (int i = 0; i < 2000 && sw_done < 9; i++) @(posedge clk);
        chk("sweep_done", 64'(sw_done), 9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/cla_pipe.md
CLA_PIPE -- requirements
Module: cla_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand/sum width; SHALL be a multiple of 4 and of 4*STAGES.
REQ-002 Parameter STAGES, default 2: pipeline depth; range 1..WIDTH/4.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 inValid  input  1  operands on a, b, cIn, sub are valid.
REQ-006 inReady  output  1  block accepts operands this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cIn  input  1  carry in; add: a+b+cIn; sub: a-b-cIn (borrow in).
REQ-010 sub  input  1  0 = add, 1 = subtract.
REQ-011 outValid  output  1  result fields valid.
REQ-012 outReady  input  1  consumer accepts result this cycle.
REQ-013 s  output  WIDTH  sum/difference, modulo 2^WIDTH.
REQ-014 cOut  output  1  carry out of bit WIDTH-1 (sub: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  s == 0.

Function
REQ-017 Operand transfer SHALL occur when inValid && inReady; result transfer when outValid && outReady.
REQ-018 Datapath SHALL be split into STAGES slices of WIDTH/STAGES bits; slice k is computed in pipeline stage k from 4-bit CLA groups joined by a lookahead carry unit; no ripple chain across all WIDTH bits in one stage.
REQ-019 Subtract SHALL be realised as a + ~b + ~cIn (b inverted and carry inverted at stage 0 input).
REQ-020 Carry out of slice k SHALL be registered and used as carry in to slice k+1 in the following stage; not-yet-processed operand bits travel with it.
REQ-021 Latency SHALL be exactly STAGES cycles from accepting transfer to outValid, with no stalls.
REQ-022 Throughput SHALL be one operation per cycle while outReady = 1.
REQ-023 Each stage SHALL hold a valid bit; the pipeline advances as a whole when advance = !outValid || outReady; otherwise every stage holds.
REQ-024 inReady SHALL equal advance, combinationally, and SHALL NOT depend on inValid.
REQ-025 When advance = 1 and no operand is transferred, a bubble (valid = 0) SHALL enter stage 0; bubbles propagate and are never presented as outValid.
REQ-026 While outValid = 1 and outReady = 0, s, cOut, ovf, zero SHALL remain stable.
REQ-027 ovf SHALL be computed as the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1 of the internal (inverted-b) addition.
REQ-028 zero SHALL be derived from the full final sum in the last stage, registered with s.
REQ-029 Simultaneous input transfer and output transfer in the same cycle SHALL both succeed with no loss or duplication.
REQ-030 Results SHALL emerge in acceptance order; no reordering.
REQ-031 STAGES = 1 SHALL degenerate to a single registered WIDTH-bit CLA with one-cycle latency.

Reset
REQ-032 While reset = 1 at a rising edge, all stage valid bits SHALL clear; outValid = 0 from the next cycle.
REQ-033 After reset, s = 0, cOut = 0, ovf = 0, zero = 0.
REQ-034 inReady SHALL be 1 in the first cycle after reset deasserts.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL be presented after reset.
REQ-036 Transfers presented while reset = 1 SHALL be ignored.

Verification (WIDTH = 32, STAGES = 2 unless noted)
REQ-037 Add with carry through: a=32'hFFFFFFFF, b=32'h00000001, cIn=0, sub=0 -> 2 cycles later s=0, cOut=1, ovf=0, zero=1.
REQ-038 Signed overflow: a=32'h7FFFFFFF, b=1, sub=0 -> s=32'h80000000, ovf=1, cOut=0; then a=32'h80000000, b=1, sub=1 -> s=32'h7FFFFFFF, ovf=1, cOut=1.
REQ-039 Back-to-back stream: 8 consecutive operations (a=i, b=3*i, i=0..7), outReady=1 -> 8 results on 8 consecutive cycles starting cycle 2, s=4*i, in order.
REQ-040 Backpressure: hold outReady=0 for 3 cycles with pipeline full -> inReady=0, s stable, no operation lost; release -> remaining results in order, one per cycle.
REQ-041 Reset mid-flight: accept 2 operations, assert reset for 1 cycle -> outValid=0 afterward, no stale result emerges; next operation returns correctly after 2 cycles.
REQ-042 Parameter sweep: random operands, WIDTH in {16, 32, 64} x STAGES in {1, 2, 4} -> s, cOut, ovf match a golden model (a±b±cIn) in every case.
